vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads own every 4th active pixel slot, the writer gets the rest.
// Read data feeds a 4-pixel replication latch; raster timing is delayed 3 stages to match.
module vram_arbiter #(
  parameter int HSZ = 10,
  parameter int VSZ = 9,
  parameter int DW  = 12,
  localparam int AW = (HSZ-2)+(VSZ-2)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          de_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic [HSZ-1:0] hcount_i,
  input  logic [VSZ-1:0] vcount_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] rgb_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state;
  logic          display_slot;
  logic          wr_accept;
  logic          rd_p0;
  logic [DW-1:0] pix_latch;
  logic [DW-1:0] pix_next;
  logic          de_p0, de_p1;
  logic          hs_p0, hs_p1;
  logic          vs_p0, vs_p1;
  logic          unused_vlow;

  // Low vcount bits only select the row inside a 4x4 cell, so they never reach the address.
  assign unused_vlow = ^vcount_i[1:0];

  assign display_slot = de_i & (hcount_i[1:0] == 2'b00);
  assign wr_ready_o   = ~display_slot;
  assign wr_accept    = wr_valid_i & ~display_slot;

  // Stage 0: slot arbitration and registered VRAM command
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (display_slot) begin
      state       <= RD;
      mem_en_o    <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {vcount_i[VSZ-1:2], hcount_i[HSZ-1:2]};
    end else if (wr_accept) begin
      state       <= WR;
      mem_en_o    <= 1'b1;
      mem_we_o    <= 1'b1;
      mem_addr_o  <= wr_addr_i;
      mem_wdata_o <= wr_data_i;
    end else begin
      state       <= IDLE;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
    end
  end

  // Read data is bypassed straight into the output register so the raster latency stays at 3.
  assign pix_next = rd_p0 ? mem_rdata_i : pix_latch;

  // Stages 1-2: read-return flag, pixel latch, timing delay line and blanked RGB
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_p0     <= 1'b0;
      pix_latch <= '0;
      rgb_o     <= '0;
      de_p0     <= 1'b0;
      de_p1     <= 1'b0;
      de_o      <= 1'b0;
      hs_p0     <= 1'b0;
      hs_p1     <= 1'b0;
      hsync_o   <= 1'b0;
      vs_p0     <= 1'b0;
      vs_p1     <= 1'b0;
      vsync_o   <= 1'b0;
    end else begin
      rd_p0     <= (state == RD);
      pix_latch <= pix_next;
      rgb_o     <= de_p1 ? pix_next : '0;
      de_p0     <= de_i;
      de_p1     <= de_p0;
      de_o      <= de_p1;
      hs_p0     <= hsync_i;
      hs_p1     <= hs_p0;
      hsync_o   <= hs_p1;
      vs_p0     <= vsync_i;
      vs_p1     <= vs_p0;
      vsync_o   <= vs_p1;
    end
  end

endmodule
